// File: rtl/instruction_fetch_if.sv
// Signal bundle between the fetch stage and its neighbours:
// the instruction memory, the decode stall and the execute redirect/training path.
interface instruction_fetch_if;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic        load_stall_if_i;
  logic        redirect_ex_i;
  logic [31:0] redirect_pc_ex_i;
  logic        branch_update_ex_i;
  logic [31:0] branch_pc_ex_i;
  logic        branch_taken_ex_i;
  logic [31:0] branch_target_ex_i;
  logic [31:0] fetched_instruction_if_o;
  logic [31:0] pc_if_o;
  logic [31:0] btb_predicted_pc_if_o;
  logic        branch_is_taken_prediction_if_o;

  modport slave (
    output imem_addr_o,
    input  imem_data_i,
    input  load_stall_if_i,
    input  redirect_ex_i,
    input  redirect_pc_ex_i,
    input  branch_update_ex_i,
    input  branch_pc_ex_i,
    input  branch_taken_ex_i,
    input  branch_target_ex_i,
    output fetched_instruction_if_o,
    output pc_if_o,
    output btb_predicted_pc_if_o,
    output branch_is_taken_prediction_if_o
  );

  modport master (
    input  imem_addr_o,
    output imem_data_i,
    output load_stall_if_i,
    output redirect_ex_i,
    output redirect_pc_ex_i,
    output branch_update_ex_i,
    output branch_pc_ex_i,
    output branch_taken_ex_i,
    output branch_target_ex_i,
    input  fetched_instruction_if_o,
    input  pc_if_o,
    input  btb_predicted_pc_if_o,
    input  branch_is_taken_prediction_if_o
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, direct-mapped BTB with 2-bit counters, and the IF/ID
// pipeline register. Execute redirects override decode stalls.
module instruction_fetch #(
  parameter int unsigned BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input logic               clk_i,
  input logic               rst_i,
  instruction_fetch_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0013;
  localparam logic [31:0] BUBBLE_PC    = 32'hFFFF_FFFC;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    if (c == 2'b11) return 2'b11;
    else            return c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    if (c == 2'b00) return 2'b00;
    else            return c - 2'b01;
  endfunction

  logic             valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
  logic [31:0]      target_q [BTB_ENTRIES];
  logic [1:0]       ctr_q    [BTB_ENTRIES];

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_if_q, pc_if_d;
  logic [31:0] npc_if_q, npc_if_d;
  logic        pred_if_q, pred_if_d;

  logic [IDX_W-1:0] look_idx_s;
  logic             look_hit_s;
  logic             pred_taken_s;
  logic [31:0]      pred_next_s;

  logic [IDX_W-1:0] upd_idx_s;
  logic             upd_hit_s;
  logic             upd_ctr_we_s;
  logic             upd_tgt_we_s;
  logic [1:0]       upd_ctr_s;

  logic unused_s;
  assign unused_s = ^{bus.redirect_pc_ex_i[1:0], bus.branch_pc_ex_i[1:0]};

  // Lookup always reads the pre-update array contents.
  always_comb begin
    look_idx_s   = pc_q[IDX_W+1:2];
    look_hit_s   = valid_q[look_idx_s] && (tag_q[look_idx_s] == pc_q[31:IDX_W+2]);
    pred_taken_s = look_hit_s && ctr_q[look_idx_s][1];
    if (pred_taken_s) pred_next_s = target_q[look_idx_s];
    else              pred_next_s = pc_q + 32'd4;
  end

  // Next PC selection: redirect beats stall beats prediction.
  always_comb begin
    if (bus.redirect_ex_i)        pc_d = {bus.redirect_pc_ex_i[31:2], 2'b00};
    else if (bus.load_stall_if_i) pc_d = pc_q;
    else                          pc_d = pred_next_s;
  end

  // IF/ID next state.
  always_comb begin
    instr_d   = instr_q;
    pc_if_d   = pc_if_q;
    npc_if_d  = npc_if_q;
    pred_if_d = pred_if_q;
    if (rst_i || bus.redirect_ex_i) begin
      instr_d   = BUBBLE_INSTR;
      pc_if_d   = BUBBLE_PC;
      npc_if_d  = 32'h0000_0000;
      pred_if_d = 1'b0;
    end else if (bus.load_stall_if_i) begin
      instr_d   = instr_q;
      pc_if_d   = pc_if_q;
      npc_if_d  = npc_if_q;
      pred_if_d = pred_if_q;
    end else begin
      instr_d   = bus.imem_data_i;
      pc_if_d   = pc_q;
      npc_if_d  = pred_next_s;
      pred_if_d = pred_taken_s;
    end
  end

  // PC and IF/ID registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
    instr_q   <= instr_d;
    pc_if_q   <= pc_if_d;
    npc_if_q  <= npc_if_d;
    pred_if_q <= pred_if_d;
  end

  // Predictor training decision for the branch resolved in execute.
  always_comb begin
    upd_idx_s    = bus.branch_pc_ex_i[IDX_W+1:2];
    upd_hit_s    = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == bus.branch_pc_ex_i[31:IDX_W+2]);
    upd_ctr_we_s = 1'b0;
    upd_tgt_we_s = 1'b0;
    upd_ctr_s    = ctr_q[upd_idx_s];
    if (!bus.branch_update_ex_i) begin
      upd_ctr_we_s = 1'b0;
    end else if (upd_hit_s) begin
      upd_ctr_we_s = 1'b1;
      if (bus.branch_taken_ex_i) begin
        upd_ctr_s    = sat_inc(ctr_q[upd_idx_s]);
        upd_tgt_we_s = 1'b1;
      end else begin
        upd_ctr_s    = sat_dec(ctr_q[upd_idx_s]);
      end
    end else if (bus.branch_taken_ex_i) begin
      upd_ctr_we_s = 1'b1;
      upd_tgt_we_s = 1'b1;
      upd_ctr_s    = 2'b10;
    end else begin
      upd_ctr_we_s = 1'b0;
    end
  end

  // Valid bits are the only predictor state that needs clearing on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BTB_ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (upd_tgt_we_s) begin
      valid_q[upd_idx_s] <= 1'b1;
    end
  end

  // Tag, target and counter arrays.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (upd_ctr_we_s) ctr_q[upd_idx_s] <= upd_ctr_s;
      if (upd_tgt_we_s) begin
        tag_q[upd_idx_s]    <= bus.branch_pc_ex_i[31:IDX_W+2];
        target_q[upd_idx_s] <= bus.branch_target_ex_i;
      end
    end
  end

  assign bus.imem_addr_o                     = pc_q;
  assign bus.fetched_instruction_if_o        = instr_q;
  assign bus.pc_if_o                         = pc_if_q;
  assign bus.btb_predicted_pc_if_o           = npc_if_q;
  assign bus.branch_is_taken_prediction_if_o = pred_if_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch with hand-computed expectations
// and a few hand-written sequences for reset and redirect corner cases.
module tb_instruction_fetch;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  instruction_fetch_if bus();

  instruction_fetch #(.BTB_ENTRIES(16), .RESET_PC(32'h0000_0000)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: each word is its address with a fixed pattern mixed in.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  assign bus.imem_data_i = mem(bus.imem_addr_o);

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] redir_pc;
    logic        upd;
    logic [31:0] upd_pc;
    logic        taken;
    logic [31:0] target;
    logic [31:0] exp_addr;
    logic        exp_bubble;
    logic [31:0] exp_pc;
    logic [31:0] exp_npc;
    logic        exp_pred;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                              input logic u, input logic [31:0] upc, input logic t,
                              input logic [31:0] tgt, input logic [31:0] ea,
                              input logic eb, input logic [31:0] epc,
                              input logic [31:0] enpc, input logic ep);
    vec_t v;
    v.stall = s; v.redir = r; v.redir_pc = rpc;
    v.upd = u; v.upd_pc = upc; v.taken = t; v.target = tgt;
    v.exp_addr = ea; v.exp_bubble = eb; v.exp_pc = epc; v.exp_npc = enpc; v.exp_pred = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Compare all five outputs against an expected state; a bubble implies fixed values.
  task automatic chk_state(input string tag, input logic [31:0] ea, input logic eb,
                           input logic [31:0] epc, input logic [31:0] enpc, input logic ep);
    logic [31:0] ei;
    logic [31:0] ep32;
    logic [31:0] enp;
    if (eb) begin
      ei = 32'h0000_0013; ep32 = 32'hFFFF_FFFC; enp = 32'h0000_0000;
    end else begin
      ei = mem(epc); ep32 = epc; enp = enpc;
    end
    chk({tag, ".addr"},  bus.imem_addr_o, ea);
    chk({tag, ".instr"}, bus.fetched_instruction_if_o, ei);
    chk({tag, ".pc"},    bus.pc_if_o, ep32);
    chk({tag, ".npc"},   bus.btb_predicted_pc_if_o, enp);
    chk({tag, ".pred"},  {31'd0, bus.branch_is_taken_prediction_if_o}, {31'd0, (eb ? 1'b0 : ep)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_stall_if_i    = 1'b0;
    bus.redirect_ex_i      = 1'b0;
    bus.redirect_pc_ex_i   = 32'h0;
    bus.branch_update_ex_i = 1'b0;
    bus.branch_pc_ex_i     = 32'h0;
    bus.branch_taken_ex_i  = 1'b0;
    bus.branch_target_ex_i = 32'h0;
  endtask

  initial begin
    // straight-line from 0
    vecs.push_back(mk(0,0,0, 0,0,0,0, 32'h04, 0, 32'h00, 32'h04, 0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 32'h08, 0, 32'h04, 32'h08, 0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 32'h0C, 0, 32'h08, 32'h0C, 0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 32'h10, 0, 32'h0C, 32'h10, 0));
    // two-cycle stall at 0x10
    vecs.push_back(mk(1,0,0, 0,0,0,0, 32'h10, 0, 32'h0C, 32'h10, 0));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 32'h10, 0, 32'h0C, 32'h10, 0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 32'h14, 0, 32'h10, 32'h14, 0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 32'h18, 0, 32'h14, 32'h18, 0));
    // allocate 0x20 -> 0x80
    vecs.push_back(mk(0,0,0, 1,32'h20,1,32'h80, 32'h1C, 0, 32'h18, 32'h1C, 0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 32'h20, 0, 32'h1C, 32'h20, 0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 32'h80, 0, 32'h20, 32'h80, 1));
    // two not-taken updates drive counter 10 -> 01 -> 00
    vecs.push_back(mk(0,0,0, 1,32'h20,0,32'h0, 32'h84, 0, 32'h80, 32'h84, 0));
    vecs.push_back(mk(0,0,0, 1,32'h20,0,32'h0, 32'h88, 0, 32'h84, 32'h88, 0));
    vecs.push_back(mk(0,1,32'h20, 0,0,0,0, 32'h20, 1, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 32'h24, 0, 32'h20, 32'h24, 0));
    // redirect to 0x103 while stalled
    vecs.push_back(mk(1,1,32'h103, 0,0,0,0, 32'h100, 1, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 32'h104, 0, 32'h100, 32'h104, 0));
    // allocate 0x140 then five more taken updates, then one not-taken
    vecs.push_back(mk(0,0,0, 1,32'h140,1,32'h200, 32'h108, 0, 32'h104, 32'h108, 0));
    vecs.push_back(mk(0,0,0, 1,32'h140,1,32'h200, 32'h10C, 0, 32'h108, 32'h10C, 0));
    vecs.push_back(mk(0,0,0, 1,32'h140,1,32'h200, 32'h110, 0, 32'h10C, 32'h110, 0));
    vecs.push_back(mk(0,0,0, 1,32'h140,1,32'h200, 32'h114, 0, 32'h110, 32'h114, 0));
    vecs.push_back(mk(0,0,0, 1,32'h140,1,32'h200, 32'h118, 0, 32'h114, 32'h118, 0));
    vecs.push_back(mk(0,0,0, 1,32'h140,1,32'h200, 32'h11C, 0, 32'h118, 32'h11C, 0));
    vecs.push_back(mk(0,0,0, 1,32'h140,0,32'h0, 32'h120, 0, 32'h11C, 32'h120, 0));
    vecs.push_back(mk(0,1,32'h140, 0,0,0,0, 32'h140, 1, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 32'h200, 0, 32'h140, 32'h200, 1));
    // alias 0x180 shares the index but not the tag
    vecs.push_back(mk(0,1,32'h180, 0,0,0,0, 32'h180, 1, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 32'h184, 0, 32'h180, 32'h184, 0));
    // PC+4 wraps at the top of the address space
    vecs.push_back(mk(0,1,32'hFFFF_FFFC, 0,0,0,0, 32'hFFFF_FFFC, 1, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 32'h0, 0, 32'hFFFF_FFFC, 32'h0, 0));

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    chk_state("reset", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.load_stall_if_i    = vecs[i].stall;
      bus.redirect_ex_i      = vecs[i].redir;
      bus.redirect_pc_ex_i   = vecs[i].redir_pc;
      bus.branch_update_ex_i = vecs[i].upd;
      bus.branch_pc_ex_i     = vecs[i].upd_pc;
      bus.branch_taken_ex_i  = vecs[i].taken;
      bus.branch_target_ex_i = vecs[i].target;
      step();
      chk_state($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_bubble,
                vecs[i].exp_pc, vecs[i].exp_npc, vecs[i].exp_pred);
    end
    idle_inputs();

    // Reset while 0x140 is being fetched with a taken prediction.
    bus.redirect_ex_i    = 1'b1;
    bus.redirect_pc_ex_i = 32'h140;
    step();
    chk_state("pre_rst", 32'h140, 1'b1, 32'h0, 32'h0, 1'b0);
    idle_inputs();
    rst = 1'b1;
    step();
    chk_state("mid_rst", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    step();
    chk_state("post_rst", 32'h4, 1'b0, 32'h0, 32'h4, 1'b0);
    bus.redirect_ex_i    = 1'b1;
    bus.redirect_pc_ex_i = 32'h140;
    step();
    idle_inputs();
    chk_state("refetch", 32'h140, 1'b1, 32'h0, 32'h0, 1'b0);
    step();
    chk_state("btb_cleared", 32'h144, 1'b0, 32'h140, 32'h144, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front end of the five-stage pipeline: holds the program counter, drives the instruction memory address, predicts the next PC through a direct-mapped BTB with 2-bit counters, and registers the fetched instruction into the IF/ID boundary consumed by instruction decode. It honours the load-use stall from decode and redirects from execute. It also trains the predictor on every branch or jump resolved in execute.

## Interface
- BTB_ENTRIES, 16: BTB depth, power of two; index = pc[log2(BTB_ENTRIES)+1:2], tag = remaining upper PC bits.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk_i  input  1  single clock, all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- imem_addr_o  output  32  word address to instruction memory (combinational read), equals current PC.
- imem_data_i  input  32  instruction at imem_addr_o, same cycle.
- load_stall_if_i  input  1  load-use stall from decode; hold PC and IF/ID register.
- redirect_ex_i  input  1  execute detected a misprediction; flush and refetch.
- redirect_pc_ex_i  input  32  correct next PC; bits [1:0] ignored (forced 00).
- branch_update_ex_i  input  1  a branch/jump resolved in execute this cycle (train BTB).
- branch_pc_ex_i  input  32  PC of the resolved instruction.
- branch_taken_ex_i  input  1  actual outcome (1 for unconditional jumps).
- branch_target_ex_i  input  32  actual taken target.
- fetched_instruction_if_o  output  32  IF/ID instruction.
- pc_if_o  output  32  IF/ID PC.
- btb_predicted_pc_if_o  output  32  next PC chosen at fetch (target or pc+4).
- branch_is_taken_prediction_if_o  output  1  predicted-taken flag.

## Operation
- BTB entry: valid, tag, 32-bit target, 2-bit counter. Hit = valid && tag match on current PC. Predict taken = hit && counter[1].
- Next-PC priority: rst_i -> RESET_PC; redirect_ex_i -> redirect_pc_ex_i; load_stall_if_i -> hold; predict taken -> BTB target; else PC+4 (mod 2^32, wraps).
- IF/ID register priority: rst_i -> bubble; redirect_ex_i -> bubble; load_stall_if_i -> hold all four outputs; else load imem_data_i, PC, chosen next PC, prediction flag.
- Bubble: instruction 32'h0000_0013 (addi x0,x0,0), pc_if_o 32'hFFFF_FFFC, btb_predicted_pc_if_o 0, prediction 0. These are also the reset values of all outputs; imem_addr_o = RESET_PC after reset.
- Training (independent of stall/redirect; suppressed only by rst_i):
  - Hit and taken: counter saturating +1 (max 11), target <= branch_target_ex_i.
  - Hit and not taken: counter saturating -1 (min 00), target unchanged.
  - Miss and taken: allocate: valid=1, tag, target, counter=10.
  - Miss and not taken: no change.
- Reset clears all valid bits synchronously; tags, targets and counters need no reset.
- Redirect and stall in the same cycle: redirect wins, stall ignored.
- Lookup and update hitting the same index in one cycle: lookup sees pre-update contents.

## Timing
- PC presented in cycle N -> its instruction on IF/ID outputs in N+1.
- Redirect asserted in N: outputs are a bubble in N+1, PC = redirect_pc in N+1, and the redirected instruction appears in N+2.
- Stall asserted in N: PC and outputs in N+1 equal those of N; fetch resumes the cycle after deassertion with no instruction lost.
- Training write visible to lookups from N+1.
- rst_i asserted mid-operation: every output is at its reset value on the next edge. The BTB is empty; first post-reset prediction = not taken.

## Test plan
- Reset, then straight-line code from 0: imem_addr_o 0,4,8,...; pc_if_o trails by one cycle; prediction 0; btb_predicted_pc_if_o = pc_if_o+4.
- Stall 2 cycles at PC 0x10: imem_addr_o stays 0x10 and outputs hold the 0x0C instruction for 2 cycles. The 0x10 instruction then appears with no gap or duplicate.
- Train taken branch at 0x20 -> 0x80 (miss, allocate counter 10). Next fetch of 0x20: prediction 1, next PC 0x80. Two not-taken updates: counter 00, predicts not taken, next PC 0x24.
- Redirect to 0x103 while stalled: one bubble (0x13, pc 0xFFFF_FFFC), then fetch from 0x100.
- Counter saturation: five taken updates keep counter 11; one not-taken still predicts taken. Alias at PC+0x40 (same index, different tag) is a miss and predicts not taken.
- Assert rst_i during a predicted-taken fetch: outputs return to bubble values, PC = RESET_PC. The previously trained PC now predicts not taken.
